// File: rtl/rgb_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_frame_writer
//  Description : Reduces framed 24-bit RGB pixels to 8 bits and writes them
//                row-major into a frame buffer. Build option GRAY_CONV_EN
//                selects luma conversion; otherwise RGB332 packing is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_frame_writer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       rgb_data,
    input  logic              rgb_done,
    input  logic              start,
    input  logic              stop,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_short,
    output logic [ADDR_W:0]   pix_count
);

    localparam int              c_total     = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] c_total_cnt = (ADDR_W + 1)'(c_total);
    localparam logic [ADDR_W:0] c_one       = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_overflow;
    logic              w_restart;
    logic              w_short;
    logic [ADDR_W:0]   w_count_after;
    logic [7:0]        w_pix;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_frame_done;
    logic              r_err_overflow;
    logic              r_err_short;
    logic [ADDR_W:0]   r_count;

`ifdef GRAY_CONV_EN
    // Coefficients sum to 256, so the 16-bit sum never exceeds 255 after >> 8.
    logic [15:0] w_luma;
    assign w_luma = 16'd77  * {8'd0, rgb_data[23:16]}
                  + 16'd150 * {8'd0, rgb_data[15:8]}
                  + 16'd29  * {8'd0, rgb_data[7:0]};
    assign w_pix  = 8'(w_luma >> 8);
`else
    assign w_pix  = {3'(rgb_data >> 21), 3'(rgb_data >> 13), 2'(rgb_data >> 6)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A same-cycle pixel is counted before stop judges the frame length.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_overflow    = 1'b0;
        w_restart     = 1'b0;
        w_short       = 1'b0;
        w_count_after = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RECV;
                    w_restart   = 1'b1;
                end
            end
            S_RECV: begin
                if (start) begin
                    w_restart = 1'b1;
                end else begin
                    if (rgb_done) begin
                        if (r_count < c_total_cnt) begin
                            w_accept      = 1'b1;
                            w_count_after = r_count + c_one;
                        end else begin
                            w_overflow = 1'b1;
                        end
                    end
                    if (stop) begin
                        w_state_nxt = S_DONE;
                        w_short     = (w_count_after < c_total_cnt);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // frame_done is registered off DONE so it always trails the final write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_frame_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_short    <= 1'b0;
            r_count        <= '0;
        end else begin
            r_wr_en      <= w_accept;
            r_frame_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_wr_addr <= r_count[ADDR_W-1:0];
                r_wr_data <= w_pix;
            end
            if (w_restart) begin
                r_count        <= '0;
                r_err_overflow <= 1'b0;
                r_err_short    <= 1'b0;
            end else begin
                r_count <= w_count_after;
                if (w_overflow) r_err_overflow <= 1'b1;
                if (w_short)    r_err_short    <= 1'b1;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state == S_RECV);
    assign err_overflow = r_err_overflow;
    assign err_short    = r_err_short;
    assign pix_count    = r_count;

endmodule
`default_nettype wire
